// File: rtl/ring_pattern_monitor.sv
// Receive-side checker for a rotating ring-counter word. It locks onto a nonzero seed,
// then checks that every sample is the right-rotation of the previous one.
module ring_pattern_monitor #(
  parameter int WIDTH      = 4,
  parameter int LOCK_COUNT = 2,
  parameter int CNT_W      = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  input  logic [WIDTH-1:0]         ring_in,
  input  logic                     clr_err,
  output logic                     locked,
  output logic                     err,
  output logic [$clog2(WIDTH)-1:0] phase,
  output logic                     wrap,
  output logic [CNT_W-1:0]         rev_cnt,
  output logic [WIDTH-1:0]         bad_pattern,
  output logic [WIDTH-1:0]         exp_next
);
  localparam int PW = $clog2(WIDTH);
  localparam int MW = $clog2(LOCK_COUNT + 1);

  typedef enum logic [1:0] {S_IDLE, S_ACQ, S_LOCK, S_ERR} state_t;

  state_t            state_q;
  logic [WIDTH-1:0]  prev_q, bad_q;
  logic [MW-1:0]     match_q;
  logic [PW-1:0]     phase_q;
  logic              wrap_q;
  logic [CNT_W-1:0]  rev_q;
  logic [WIDTH-1:0]  rot_prev;
  logic              hit, zero;

  assign rot_prev = {prev_q[0], prev_q[WIDTH-1:1]};
  assign hit      = (ring_in == rot_prev);
  assign zero     = (ring_in == '0);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      prev_q  <= '0;
      bad_q   <= '0;
      match_q <= '0;
      phase_q <= '0;
      wrap_q  <= 1'b0;
      rev_q   <= '0;
    end else begin
      wrap_q <= 1'b0;
      // A clear request leaves ERROR even when no sample is offered.
      if (clr_err && state_q == S_ERR) begin
        state_q <= S_IDLE;
      end else if (in_valid) begin
        unique case (state_q)
          S_IDLE: if (!zero) begin
            prev_q  <= ring_in;
            match_q <= '0;
            phase_q <= '0;
            state_q <= S_ACQ;
          end
          S_ACQ: begin
            if (hit) begin
              prev_q  <= ring_in;
              phase_q <= phase_q + PW'(1);
              match_q <= match_q + MW'(1);
              if (match_q + MW'(1) == MW'(LOCK_COUNT)) state_q <= S_LOCK;
            end else if (zero) begin
              state_q <= S_IDLE;
            end else begin
              prev_q  <= ring_in;
              phase_q <= '0;
              match_q <= '0;
            end
          end
          S_LOCK: begin
            if (hit) begin
              prev_q  <= ring_in;
              phase_q <= phase_q + PW'(1);
              if (phase_q == PW'(WIDTH - 1)) begin
                wrap_q <= 1'b1;
                if (rev_q != {CNT_W{1'b1}}) rev_q <= rev_q + CNT_W'(1);
              end
            end else if (zero) begin
              state_q <= S_IDLE;
            end else begin
              state_q <= S_ERR;
              bad_q   <= ring_in;
            end
          end
          S_ERR: if (zero) state_q <= S_IDLE;
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign locked      = (state_q == S_LOCK);
  assign err         = (state_q == S_ERR);
  assign phase       = phase_q;
  assign wrap        = wrap_q;
  assign rev_cnt     = rev_q;
  assign bad_pattern = bad_q;
  assign exp_next    = (state_q == S_IDLE) ? '0 : rot_prev;
endmodule
